// File: rtl/dds_clkdiv_axil_regs.sv
// AXI4-Lite register bank for the DDS sampling clock divider: CTRL, CLK_DIV,
// a sample-enable counter and a constant ID word.
module dds_clkdiv_axil_regs #(
  parameter int          ADDR_W     = 4,
  parameter logic [31:0] CLKDIV_RST = 32'd4,
  parameter logic [31:0] IP_ID      = 32'hDD5C_0001
) (
  input  logic              clk,
  input  logic              a_rst_n,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  input  logic              i_sample_en,
  output logic [31:0]       o_ckdivider_clk_div_reg,
  output logic [31:0]       o_ckdivider_ctrl_reg
);

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_CLK_DIV = 2'd1;
  localparam logic [1:0] REG_CNT     = 2'd2;
  localparam logic [1:0] REG_ID      = 2'd3;

  logic        aw_held_q, aw_held_d;
  logic [1:0]  aw_sel_q, aw_sel_d;
  logic        w_held_q, w_held_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        start_q, start_d;
  logic        rst_pulse_q, rst_pulse_d;
  logic [31:0] clk_div_q, clk_div_d;
  logic [31:0] sample_cnt_q, sample_cnt_d;

  logic        aw_hs_s, w_hs_s, ar_hs_s, wr_commit_s;
  logic [31:0] clk_div_merged_s;
  logic        unused_ok;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] read_mux(input logic [1:0]  sel,
                                           input logic        start,
                                           input logic [31:0] clk_div,
                                           input logic [31:0] cnt);
    logic [31:0] res;
    case (sel)
      REG_CTRL:    res = {30'd0, start, 1'b0};
      REG_CLK_DIV: res = clk_div;
      REG_CNT:     res = cnt;
      REG_ID:      res = IP_ID;
      default:     res = 32'd0;
    endcase
    return res;
  endfunction

  assign aw_hs_s          = s_axil_awvalid & awready_q;
  assign w_hs_s           = s_axil_wvalid & wready_q;
  assign ar_hs_s          = s_axil_arvalid & arready_q;
  assign wr_commit_s      = aw_held_q & w_held_q & ~bvalid_q;
  assign clk_div_merged_s = apply_strb(clk_div_q, wdata_q, wstrb_q);
  assign unused_ok        = &{1'b0, s_axil_awaddr, s_axil_araddr};

  // Next-state logic for both AXI channels and the divider-facing registers
  always_comb begin
    aw_held_d    = aw_held_q;
    aw_sel_d     = aw_sel_q;
    w_held_d     = w_held_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bvalid_d     = bvalid_q;
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;
    start_d      = start_q;
    rst_pulse_d  = 1'b0;
    clk_div_d    = clk_div_q;
    sample_cnt_d = sample_cnt_q;

    if (aw_hs_s) begin
      aw_held_d = 1'b1;
      aw_sel_d  = s_axil_awaddr[3:2];
    end else begin
      aw_sel_d  = aw_sel_q;
    end

    if (w_hs_s) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil_wdata;
      wstrb_d  = s_axil_wstrb;
    end else begin
      wdata_d  = wdata_q;
    end

    if (wr_commit_s) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      case (aw_sel_q)
        REG_CTRL: begin
          if (wstrb_q[0]) begin
            rst_pulse_d = wdata_q[0];
            start_d     = wdata_q[1];
          end else begin
            start_d     = start_q;
          end
        end
        REG_CLK_DIV: clk_div_d = (clk_div_merged_s == 32'd0) ? 32'd1 : clk_div_merged_s;
        default: clk_div_d = clk_div_q;
      endcase
    end else if (bvalid_q && s_axil_bready) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end

    // The RST pulse clear takes priority over a coincident sample strobe
    if (rst_pulse_q) begin
      sample_cnt_d = 32'd0;
    end else if (i_sample_en) begin
      sample_cnt_d = sample_cnt_q + 32'd1;
    end else begin
      sample_cnt_d = sample_cnt_q;
    end

    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      rdata_d  = read_mux(s_axil_araddr[3:2], start_q, clk_div_q, sample_cnt_q);
    end else if (rvalid_q && s_axil_rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end

    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
    arready_d = ~rvalid_d;
  end

  // State registers; async reset returns every output to its idle value
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      aw_held_q    <= 1'b0;
      aw_sel_q     <= 2'd0;
      w_held_q     <= 1'b0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
      start_q      <= 1'b0;
      rst_pulse_q  <= 1'b0;
      clk_div_q    <= CLKDIV_RST;
      sample_cnt_q <= 32'd0;
    end else begin
      aw_held_q    <= aw_held_d;
      aw_sel_q     <= aw_sel_d;
      w_held_q     <= w_held_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      start_q      <= start_d;
      rst_pulse_q  <= rst_pulse_d;
      clk_div_q    <= clk_div_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign s_axil_awready          = awready_q;
  assign s_axil_wready           = wready_q;
  assign s_axil_bvalid           = bvalid_q;
  assign s_axil_bresp            = 2'b00;
  assign s_axil_arready          = arready_q;
  assign s_axil_rvalid           = rvalid_q;
  assign s_axil_rdata            = rdata_q;
  assign s_axil_rresp            = 2'b00;
  assign o_ckdivider_clk_div_reg = clk_div_q;
  assign o_ckdivider_ctrl_reg    = {30'd0, start_q, rst_pulse_q};

endmodule

// File: doc/dds_clkdiv_axil_regs.md
Name: dds_clkdiv_axil_regs

Overview:
AXI4-Lite slave register bank that drives the DDS sampling clock divider's control and divide registers.
Counts the divider's sample-enable pulses back into a readable status register.
Sits between the PS/interconnect AXI-Lite master and the sampling divider, in the same clk domain.
Single outstanding write and single outstanding read; registered (non-combinational) ready/valid outputs.

Parameters:
- ADDR_W, 4, AXI-Lite address width (byte address; only bits [3:2] decoded).
- CLKDIV_RST, 4, reset value of CLK_DIV register.
- IP_ID, 32'hDD5C_0001, constant returned by ID register.

Ports:
- clk  in  1  clock.
- a_rst_n  in  1  reset, asynchronous, active-low.
- s_axil_awaddr  in  ADDR_W  write address.
- s_axil_awvalid  in  1  write address valid.
- s_axil_awready  out  1  write address ready.
- s_axil_wdata  in  32  write data.
- s_axil_wstrb  in  4  byte strobes.
- s_axil_wvalid  in  1  write data valid.
- s_axil_wready  out  1  write data ready.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid  out  1  write response valid.
- s_axil_bready  in  1  write response ready.
- s_axil_araddr  in  ADDR_W  read address.
- s_axil_arvalid  in  1  read address valid.
- s_axil_arready  out  1  read address ready.
- s_axil_rdata  out  32  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid  out  1  read data valid.
- s_axil_rready  in  1  read data ready.
- i_sample_en  in  1  one-cycle strobe from divider.
- o_ckdivider_clk_div_reg  out  32  divide value to divider.
- o_ckdivider_ctrl_reg  out  32  control word to divider (bit0 RST, bit1 START).

Behaviour:
Register map (byte offset):
- 0x0 CTRL, RW:
  - bit0 RST is self-clearing: reads 0; a write with bit0=1 drives o_ckdivider_ctrl_reg[0]=1 for exactly one clk.
  - bit1 START is a plain RW bit.
  - bits[31:2] read 0 and ignore writes.
- 0x4 CLK_DIV, RW:
  - Byte-strobed.
  - If the post-strobe value is 0, 1 is stored instead; the divider never sees 0.
- 0x8 SAMPLE_CNT, RO:
  - 32-bit; increments on each i_sample_en; wraps 0xFFFFFFFF->0.
  - Cleared when the RST pulse is active; clear wins over a simultaneous i_sample_en.
- 0xC ID, RO: returns IP_ID.
- Writes to RO registers are ignored; BRESP=OKAY.
- Byte offsets are word-aligned by ignoring addr[1:0].

Reset values:
- awready=wready=arready=0 during reset, 1 on the first cycle after reset release.
- bvalid=rvalid=0; bresp=rresp=0; rdata=0.
- CTRL=0; CLK_DIV=CLKDIV_RST; SAMPLE_CNT=0.

Write channel:
- AW and W are accepted independently into holding registers.
- awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
- Either order, or the same cycle, is legal.
- On the first edge where both are held (or handshaking) and bvalid=0:
  - Register update and bvalid=1 occur at the next edge (1-cycle latency after the later handshake).
  - Holding flags clear at that edge.
- bvalid stays high until bready; no new AW/W is accepted while bvalid=1.
- o_ckdivider_* outputs reflect a new value on the same edge bvalid rises.

Read channel:
- arready = !rvalid.
- On the AR handshake edge, rdata/rresp are registered and rvalid=1 from the next cycle.
- rdata stays stable until rready; arready returns high the cycle after the R handshake.
- A read and a write to the same register completing on the same edge: the read returns the old value.

RST pulse:
- Also forces an internal sample_cnt clear.
- START is unaffected unless written.

Reset mid-transaction:
- a_rst_n low aborts all pending AW/W/B/AR/R immediately; all outputs return to reset values asynchronously.

Test Plan:
- Post-reset: read 0x4, 0x0, 0xC -> rdata 4, 0, 0xDD5C0001; all rresp=0; rvalid 1 cycle after AR handshake.
- W before AW: W 0x0000000A at T, AW 0x4 at T+3 -> bvalid at T+4; o_ckdivider_clk_div_reg=10 at T+4; readback 10.
- WSTRB=4'b0010, data 0x0000_3400 to CLK_DIV=10 -> 0x340A. Write 0 with wstrb=4'hF -> reads 1.
- Write CTRL=0x3 -> o_ckdivider_ctrl_reg[0]=1 for exactly 1 clk, then bit1 only. CTRL read returns 0x2.
- SAMPLE_CNT:
  - Pulse i_sample_en 5 times -> reads 5.
  - RST write with i_sample_en on the pulse cycle -> reads 0.
  - Preload path: after 0xFFFFFFFF+1 pulses -> 0.
- Backpressure: hold bready=0 and rready=0 for 10 cycles -> bvalid/rvalid/rdata stable, awready=wready=arready=0. Assert a_rst_n low mid-transaction -> all valids 0 immediately.
